// File: rtl/sparse_layer_pkg.sv
// Shared types and constants for the sparse lookup-table layer pipeline.
// Holds the controller state encoding, default geometry and the width helper.
package sparse_layer_pkg;

  typedef enum logic [1:0] {
    ST_CFG   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_IN_NEURONS  = 32;
  localparam int DEF_IN_BITS     = 2;
  localparam int DEF_OUT_NEURONS = 16;
  localparam int DEF_OUT_BITS    = 2;
  localparam int DEF_FAN_IN      = 4;

  // Never returns zero so that a single-entry dimension still gets a 1-bit port.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sparse_layer_neuron.sv
// One output neuron: a 2^ADDR_BITS deep lookup table with a synchronous
// write port and an asynchronous read port. Contents are never reset.
module sparse_layer_neuron
  import sparse_layer_pkg::*;
#(
  parameter int ADDR_BITS = DEF_FAN_IN * DEF_IN_BITS,
  parameter int OUT_BITS  = DEF_OUT_BITS
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [OUT_BITS-1:0]  wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [OUT_BITS-1:0]  rd_data
);

  logic [OUT_BITS-1:0] lut [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) lut[wr_addr] <= wr_data;
  end

  assign rd_data = lut[rd_addr];

endmodule

// File: rtl/sparse_layer_pipe.sv
// Sparse layer: each output neuron looks up a table addressed by FAN_IN
// selected input neurons. Tables are loaded in CFG, inference runs in RUN.
module sparse_layer_pipe
  import sparse_layer_pkg::*;
#(
  parameter int IN_NEURONS  = DEF_IN_NEURONS,
  parameter int IN_BITS     = DEF_IN_BITS,
  parameter int OUT_NEURONS = DEF_OUT_NEURONS,
  parameter int OUT_BITS    = DEF_OUT_BITS,
  parameter int FAN_IN      = DEF_FAN_IN,
  parameter logic [OUT_NEURONS*FAN_IN*clog2(IN_NEURONS)-1:0] CONN = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [IN_NEURONS*IN_BITS-1:0]   in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                            cfg_start,
  input  logic                            cfg_done,
  input  logic                            cfg_we,
  input  logic [clog2(OUT_NEURONS)-1:0]   cfg_neuron,
  input  logic [FAN_IN*IN_BITS-1:0]       cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data,
  output logic                            cfg_mode,
  output logic                            cfg_err
);

  localparam int CW = clog2(IN_NEURONS);
  localparam int A  = FAN_IN * IN_BITS;
  localparam int NW = clog2(OUT_NEURONS);

  state_t state;
  logic   accept;
  logic   neuron_in_range;
  logic   table_we;
  logic   illegal_write;
  logic [31:0] neuron_ext;
  wire  [OUT_NEURONS*OUT_BITS-1:0] lut_data;

  function automatic int conn_idx(input int n, input int j);
    return int'(CONN[(n*FAN_IN+j)*CW +: CW]);
  endfunction

  assign neuron_ext      = 32'(cfg_neuron);
  assign neuron_in_range = neuron_ext < 32'(OUT_NEURONS);
  assign table_we        = cfg_we && (state == ST_CFG) && neuron_in_range;
  assign illegal_write   = cfg_we && !((state == ST_CFG) && neuron_in_range);

  assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  for (genvar n = 0; n < OUT_NEURONS; n++) begin : g_neuron
    logic [A-1:0] rd_addr;
    logic         we;

    for (genvar j = 0; j < FAN_IN; j++) begin : g_conn_check
      if (conn_idx(n, j) >= IN_NEURONS) begin : g_bad_conn
        $fatal(1, "sparse_layer_pipe: CONN entry refers to a non-existent input neuron");
      end
    end

    // Gather the selected input neurons into this neuron's table address.
    always_comb begin
      rd_addr = '0;
      for (int j = 0; j < FAN_IN; j++) begin
        rd_addr[j*IN_BITS +: IN_BITS] = in_data[conn_idx(n, j)*IN_BITS +: IN_BITS];
      end
    end

    assign we = table_we && (cfg_neuron == NW'(n));

    sparse_layer_neuron #(
      .ADDR_BITS (A),
      .OUT_BITS  (OUT_BITS)
    ) u_neuron (
      .clk     (clk),
      .we      (we),
      .wr_addr (cfg_addr),
      .wr_data (cfg_data),
      .rd_addr (rd_addr),
      .rd_data (lut_data[n*OUT_BITS +: OUT_BITS])
    );
  end

  // Controller and output stage; a new accept overrides a drain so the
  // pipe keeps full throughput under continuous out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_CFG;
      cfg_mode  <= 1'b1;
      cfg_err   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (illegal_write) cfg_err <= 1'b1;

      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= lut_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_CFG: begin
          if (cfg_done) begin
            state    <= ST_RUN;
            cfg_mode <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cfg_start) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!out_valid) begin
            state    <= ST_CFG;
            cfg_mode <= 1'b1;
          end
        end
        default: begin
          state    <= ST_CFG;
          cfg_mode <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/sparse_layer_pipe.md
SPARSE_LAYER_PIPE -- requirements
Module: sparse_layer_pipe

Interface
REQ-001 SHALL have parameter IN_NEURONS, default 32, number of input neurons.
REQ-002 SHALL have parameter IN_BITS, default 2, bits per input neuron.
REQ-003 SHALL have parameter OUT_NEURONS, default 16, number of output neurons.
REQ-004 SHALL have parameter OUT_BITS, default 2, bits per output neuron.
REQ-005 SHALL have parameter FAN_IN, default 4, inputs per output neuron; table address width A = FAN_IN*IN_BITS (default 8).
REQ-006 SHALL have parameter CONN, default all-zero, flattened OUT_NEURONS*FAN_IN input indices, each CW = clog2(IN_NEURONS) bits; entry n*FAN_IN+j is at CONN[(n*FAN_IN+j)*CW +: CW].
REQ-007 SHALL have ports clk input 1 (rising-edge clock) and rst_n input 1 (synchronous, active-low reset).
REQ-008 SHALL have in_valid input 1, in_ready output 1, in_data input IN_NEURONS*IN_BITS (neuron i at [i*IN_BITS +: IN_BITS]).
REQ-009 SHALL have out_valid output 1, out_ready input 1, out_data output OUT_NEURONS*OUT_BITS (neuron n at [n*OUT_BITS +: OUT_BITS]).
REQ-010 SHALL have cfg_start input 1, cfg_done input 1, cfg_we input 1, cfg_neuron input clog2(OUT_NEURONS), cfg_addr input A, cfg_data input OUT_BITS.
REQ-011 SHALL have cfg_mode output 1 (high in CFG state) and cfg_err output 1 (sticky illegal-write flag).

Function
REQ-012 SHALL implement FSM states CFG, RUN, DRAIN; reset state CFG.
REQ-013 CFG: cfg_we=1 SHALL write cfg_data into table of neuron cfg_neuron at cfg_addr, visible from the next cycle; cfg_neuron >= OUT_NEURONS SHALL be ignored and set cfg_err.
REQ-014 CFG -> RUN on cfg_done=1; cfg_we in the same cycle SHALL still be written.
REQ-015 RUN -> DRAIN on cfg_start=1; DRAIN -> CFG in the first cycle with out_valid=0 (same-cycle if already empty).
REQ-016 cfg_we=1 outside CFG SHALL be ignored and set cfg_err; cfg_err clears only on reset.
REQ-017 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready); a transfer occurs when in_valid && in_ready.
REQ-018 Per output neuron n, address bits [j*IN_BITS +: IN_BITS] SHALL equal input neuron CONN index (n,j); out_data field n SHALL be table_n[address].
REQ-019 Latency SHALL be exactly 1 cycle: accepted input registers into out_data with out_valid=1 on the next edge.
REQ-020 out_valid SHALL clear on out_valid && out_ready without a simultaneous transfer; simultaneous accept and drain SHALL keep out_valid=1 with new data (full throughput).
REQ-021 out_data SHALL hold stable while out_valid && !out_ready.
REQ-022 cfg_start and cfg_done asserted in states where they have no transition SHALL be ignored.
REQ-023 CONN indices >= IN_NEURONS SHALL be rejected at elaboration.

Reset
REQ-024 rst_n=0 at a clock edge SHALL set state=CFG, out_valid=0, out_data=0, cfg_err=0, in_ready=0, cfg_mode=1, including mid-stream (pending output discarded).
REQ-025 Table contents SHALL NOT be reset; they retain values across reset and are undefined until written.

Structure
REQ-026 Package sparse_layer_pkg SHALL hold the state enum, default parameter constants and the clog2 helper.
REQ-027 Sub-module sparse_layer_neuron (one per output neuron: 2^A x OUT_BITS table, write port, combinational read) SHALL be instantiated by generate.
REQ-028 Output register and FSM SHALL reside in sparse_layer_pipe; no other sequential logic.

Verification
REQ-029 Config all 16 tables as table[a]=a[1:0], CONN(n,0)=n, cfg_done, send in_data with neuron i = i%4 -> out_data neuron n = n%4 one cycle later.
REQ-030 Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> first result held, in_ready=0, no loss/duplication of 10 back-to-back vectors.
REQ-031 Streaming with out_ready=1: 100 random vectors -> 100 outputs in order matching reference model, out_valid continuous after first.
REQ-032 cfg_start while out_valid=1, out_ready=0 -> DRAIN, in_ready=0, CFG entered the cycle after output consumed; cfg_we in RUN -> cfg_err=1, table unchanged.
REQ-033 rst_n=0 mid-stream -> next cycle out_valid=0, out_data=0, cfg_mode=1; tables keep prior contents (cfg_done then reproduces REQ-029 results).
